bist_misr_checker: RTL and testbench
====================================

# bist_misr_checker

Response-compaction stage of the BIST datapath, sitting directly downstream of the 8:1 six-bit result multiplexer. It drives the multiplexer's 3-bit select and sweeps all eight channels for a programmable number of rounds. Each selected 6-bit word is folded into a multiple-input signature register (MISR). At the end of the session it compares the signature against a golden value and reports pass/fail to the BIST controller over a start/done handshake.

## Interface
- ROUNDS, default 4: number of full 8-channel sweeps per session (1..255).
- SEED, default 6'h00: MISR value loaded at session start.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  session request; sampled only in IDLE.
- gold  input  6  expected signature; sampled in CHECK.
- din  input  6  multiplexer output, valid in the same cycle as `sel`.
- sel  output  3  multiplexer select, registered.
- busy  output  1  high from the cycle after `start` is accepted through CHECK.
- done  output  1  one-cycle pulse when the result is valid.
- pass  output  1  1 = signature matched; held until the next accepted `start`.

## Operation
- FSM states:
  - IDLE -> SWEEP on `start`=1. Entering SWEEP loads sig=SEED, sel=0, round=0.
  - SWEEP: each cycle sig <= misr(sig, din), then sel increments. When sel wraps 7->0, round increments. After sel=7 of round ROUNDS-1 -> CHECK.
  - CHECK: pass <= (sig == gold); done <= 1; -> IDLE.
- MISR polynomial is x^6+x+1:
  - n[0] = s[5]^d[0]
  - n[1] = s[0]^s[5]^d[1]
  - n[i] = s[i-1]^d[i] for i = 2..5
- Session length is exactly 8*ROUNDS SWEEP cycles. Every channel is compacted exactly ROUNDS times.
- `start` during SWEEP or CHECK is ignored; it is not queued.
- `start` held high across done: a new session begins from IDLE on the next cycle.
- sel is 3 bits and wraps naturally. The round counter is 8 bits and is compared against ROUNDS-1.
- `pass` is cleared to 0 when a new `start` is accepted.

## Timing
- Reset values:
  - sel=0, busy=0, done=0, pass=0
  - sig=SEED, state IDLE, round=0
- The `start` edge at cycle t gives SWEEP in t+1, with sel=0 visible in t+1.
- din is sampled in the same cycle its sel is presented, because the multiplexer is combinational. There is no extra pipeline stage.
- The last SWEEP cycle is t+8*ROUNDS. CHECK runs in the next cycle; done and pass are registered and visible one cycle after CHECK.
- Total latency from the `start` cycle to `done`=1 is 8*ROUNDS+2 cycles.
- rst_n=0 at any point, including mid-SWEEP, returns the block to reset values at that edge. No partial result is reported.

## Configuration
- Macro `BIST_MISR_SIG_OUT_EN`.
- When defined: an extra output port `sig` (6 bits) exposes the live MISR register for debug and diagnosis. Its reset value is SEED.
- When undefined: the port is absent and the block behaves identically otherwise.

## Structure
- Shared package `bist_pkg` holds:
  - the FSM state enum (IDLE, SWEEP, CHECK)
  - the MISR width constant (6)
  - the polynomial tap mask 6'b000011
  - a `misr_next` function
- One sub-module: `misr6`, the register plus next-state logic, with ports clk, rst_n, load, seed, en, d, q. The FSM and counters stay in the top level.

## Test plan
- ROUNDS=1, SEED=0, din=0 always, gold=6'h00: done exactly 10 cycles after start, with pass=1.
- Same configuration with gold=6'h01: done pulses and pass=0.
- ROUNDS=1, SEED=0, din=6'h01 only while sel=0 and 0 otherwise:
  - signature is 6'h06
  - gold=6'h06 gives pass=1
  - sel sequence observed is 0..7
- ROUNDS=4: sel wraps 4 times, busy is high for 33 cycles, and done arrives 34 cycles after start. Compare against the bench MISR model with random din.
- rst_n low mid-SWEEP (cycle 5): next cycle sel=0, busy=0, done=0, pass=0. No done follows; a new start runs a full, correct session.
- start pulsed during SWEEP is ignored, so the session length is unchanged. start held high continuously gives back-to-back sessions, with pass cleared at each acceptance.

Source files
------------

// File: rtl/bist_misr_checker_pkg.sv
// Shared types and MISR helpers for the BIST response-compaction stage.
// The polynomial is x^6+x+1: the shifted-out MSB feeds back into bits 0 and 1.
package bist_pkg;

   localparam int MISR_W = 6;
   localparam logic [MISR_W-1:0] TAP_MASK = 6'b000011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      CHECK = 2'd2
   } state_t;

   function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                   input logic [MISR_W-1:0] d);
      logic [MISR_W-1:0] fb;
      fb = s[MISR_W-1] ? TAP_MASK : '0;
      return {s[MISR_W-2:0], 1'b0} ^ fb ^ d;
   endfunction

endpackage

// File: rtl/bist_misr_checker_if.sv
// Controller/mux-facing bundle of the checker: start/done handshake, mux select/data, golden value.
// master = BIST controller plus result mux; slave = the checker itself.
interface bist_misr_checker_if;
   import bist_pkg::*;

   logic              start;
   logic [MISR_W-1:0] gold;
   logic [MISR_W-1:0] din;
   logic [2:0]        sel;
   logic              busy;
   logic              done;
   logic              pass;

   modport master (
      output start, gold, din,
      input  sel, busy, done, pass
   );

   modport slave (
      input  start, gold, din,
      output sel, busy, done, pass
   );

endinterface

// File: rtl/bist_misr_checker_misr6.sv
// Six-bit multiple-input signature register: load takes priority over compaction.
// One-cycle update; reset and load both return the register to the seed.
module misr6
   import bist_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [MISR_W-1:0] seed,
   input  logic              en,
   input  logic [MISR_W-1:0] d,
   output logic [MISR_W-1:0] q
);

   logic [MISR_W-1:0] q_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_r <= seed;
      end else if (load) begin
         q_r <= seed;
      end else if (en) begin
         q_r <= misr_next(q_r, d);
      end
   end

   assign q = q_r;

endmodule

// File: rtl/bist_misr_checker.sv
// Sweeps the 8:1 result mux ROUNDS times, folds each word into a MISR, then checks it against gold.
// start to done is 8*ROUNDS+2 cycles; start is ignored while busy. Macro BIST_MISR_SIG_OUT_EN adds a debug sig port.
module bist_misr_checker
   import bist_pkg::*;
#(
   parameter int unsigned       ROUNDS = 4,
   parameter logic [MISR_W-1:0] SEED   = 6'h00
) (
   input logic               clk,
   input logic               rst_n,
   bist_misr_checker_if.slave bus
`ifdef BIST_MISR_SIG_OUT_EN
   ,
   output logic [MISR_W-1:0] sig
`endif
);

   localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

   state_t            state_q, state_d;
   logic [2:0]        sel_q, sel_d;
   logic [7:0]        round_q, round_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              misr_load;
   logic              misr_en;
   logic [MISR_W-1:0] sig_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         round_q <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         round_q <= round_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      round_d   = round_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pass_d    = pass_q;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = SWEEP;
               sel_d     = 3'd0;
               round_d   = 8'd0;
               busy_d    = 1'b1;
               pass_d    = 1'b0;
               misr_load = 1'b1;
            end
         end
         SWEEP: begin
            // din belongs to the select presented this cycle, so compact before advancing sel
            misr_en = 1'b1;
            sel_d   = sel_q + 3'd1;
            if (sel_q == 3'd7) begin
               round_d = round_q + 8'd1;
               if (round_q == LAST_ROUND) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            pass_d  = (sig_q == bus.gold);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   misr6 u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (misr_load),
      .seed  (SEED),
      .en    (misr_en),
      .d     (bus.din),
      .q     (sig_q)
   );

   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.pass = pass_q;

`ifdef BIST_MISR_SIG_OUT_EN
   assign sig = sig_q;
`endif

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench for bist_misr_checker: one ROUNDS=1 and one ROUNDS=4 instance, both SEED=0.
module tb_bist_misr_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   bist_misr_checker_if b1 ();
   bist_misr_checker_if b4 ();

   bist_misr_checker #(.ROUNDS(1), .SEED(6'h00)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1)
   );

   bist_misr_checker #(.ROUNDS(4), .SEED(6'h00)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b4)
   );

   int checks = 0;
   int passes = 0;

   typedef struct {
      bit         w4;        // 1 = ROUNDS=4 instance
      int         mode;      // 0 zero, 1 one@sel0, 2 one@sel7, 3 random
      logic [5:0] gold;      // random mode: XOR applied to the model signature
      bit         exp_pass;
      bit         inj;       // pulse start during SWEEP
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [5:0] model(input logic [5:0] s, input logic [5:0] d);
      logic [5:0] r;
      r[0] = s[5] ^ d[0];
      r[1] = s[0] ^ s[5] ^ d[1];
      for (int i = 2; i < 6; i++) r[i] = s[i-1] ^ d[i];
      return r;
   endfunction

   function automatic logic [2:0] get_sel(input bit w);
      return w ? b4.sel : b1.sel;
   endfunction
   function automatic logic get_busy(input bit w);
      return w ? b4.busy : b1.busy;
   endfunction
   function automatic logic get_done(input bit w);
      return w ? b4.done : b1.done;
   endfunction
   function automatic logic get_pass(input bit w);
      return w ? b4.pass : b1.pass;
   endfunction

   task automatic set_in(input bit w, input logic s, input logic [5:0] g, input logic [5:0] d);
      if (w) begin
         b4.start = s; b4.gold = g; b4.din = d;
      end else begin
         b1.start = s; b1.gold = g; b1.din = d;
      end
   endtask

   task automatic run_session(input bit w, input int mode, input logic [5:0] gold,
                              input bit exp_pass, input bit inj, input string name);
      int         n;
      int         lat;
      int         sel_err;
      int         busy_n;
      bit         got_done;
      logic       pass_v;
      logic [5:0] ms;
      logic [5:0] d;
      logic [5:0] g;
      logic [2:0] s;
      n        = w ? 32 : 8;
      ms       = 6'h00;
      lat      = 0;
      sel_err  = 0;
      busy_n   = 0;
      got_done = 1'b0;
      pass_v   = 1'b0;
      g        = (mode == 3) ? 6'h00 : gold;
      @(negedge clk);
      set_in(w, 1'b1, g, 6'h00);
      for (int k = 1; k <= 200 && !got_done; k++) begin
         @(negedge clk);
         lat = k;
         d   = 6'h00;
         if (k <= n) begin
            s = get_sel(w);
            if (s != 3'((k - 1) % 8)) sel_err++;
            case (mode)
               1:       d = (s == 3'd0) ? 6'h01 : 6'h00;
               2:       d = (s == 3'd7) ? 6'h01 : 6'h00;
               3:       d = 6'($urandom & 32'h3f);
               default: d = 6'h00;
            endcase
            ms = model(ms, d);
         end
         if (mode == 3 && k >= n) g = ms ^ gold;
         set_in(w, inj && (k == 3), g, d);
         if (get_busy(w)) busy_n++;
         if (get_done(w)) begin
            got_done = 1'b1;
            pass_v   = get_pass(w);
         end
      end
      chk({name, "_latency"}, lat, n + 2);
      chk({name, "_sel_seq_errs"}, sel_err, 0);
      chk({name, "_busy_cycles"}, busy_n, n + 1);
      chk({name, "_pass"}, int'(pass_v), int'(exp_pass));
      @(negedge clk);
      chk({name, "_done_one_cycle"}, int'(get_done(w)), 0);
   endtask

   initial begin
      int cnt;
      tbl[0] = '{w4: 1'b0, mode: 0, gold: 6'h00, exp_pass: 1'b1, inj: 1'b0};
      tbl[1] = '{w4: 1'b0, mode: 0, gold: 6'h01, exp_pass: 1'b0, inj: 1'b0};
      tbl[2] = '{w4: 1'b0, mode: 1, gold: 6'h06, exp_pass: 1'b1, inj: 1'b0};
      tbl[3] = '{w4: 1'b0, mode: 1, gold: 6'h07, exp_pass: 1'b0, inj: 1'b0};
      tbl[4] = '{w4: 1'b0, mode: 2, gold: 6'h01, exp_pass: 1'b1, inj: 1'b0};
      tbl[5] = '{w4: 1'b1, mode: 3, gold: 6'h00, exp_pass: 1'b1, inj: 1'b0};
      tbl[6] = '{w4: 1'b1, mode: 3, gold: 6'h04, exp_pass: 1'b0, inj: 1'b1};
      tbl[7] = '{w4: 1'b0, mode: 1, gold: 6'h06, exp_pass: 1'b1, inj: 1'b1};

      rst_n = 1'b0;
      set_in(1'b0, 1'b0, 6'h00, 6'h00);
      set_in(1'b1, 1'b0, 6'h00, 6'h00);
      repeat (2) @(negedge clk);
      chk("rst_sel_r1", int'(b1.sel), 0);
      chk("rst_busy_r1", int'(b1.busy), 0);
      chk("rst_done_r1", int'(b1.done), 0);
      chk("rst_pass_r1", int'(b1.pass), 0);
      chk("rst_sel_r4", int'(b4.sel), 0);
      chk("rst_busy_r4", int'(b4.busy), 0);
      chk("rst_done_r4", int'(b4.done), 0);
      chk("rst_pass_r4", int'(b4.pass), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_session(tbl[i].w4, tbl[i].mode, tbl[i].gold, tbl[i].exp_pass, tbl[i].inj,
                     $sformatf("vec%0d", i));

      // Mid-SWEEP reset: leave pass=1 first so the clear is observable.
      run_session(1'b1, 3, 6'h00, 1'b1, 1'b0, "pre_rst");
      @(negedge clk);
      set_in(1'b1, 1'b1, 6'h00, 6'h00);
      @(negedge clk);
      set_in(1'b1, 1'b0, 6'h00, 6'h15);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_sel", int'(b4.sel), 0);
      chk("midrst_busy", int'(b4.busy), 0);
      chk("midrst_done", int'(b4.done), 0);
      chk("midrst_pass", int'(b4.pass), 0);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (b4.done || b4.busy) cnt++;
      end
      chk("midrst_no_done_or_busy", cnt, 0);
      run_session(1'b1, 3, 6'h00, 1'b1, 1'b0, "post_rst");

      // start held high: back-to-back sessions on the ROUNDS=1 instance.
      @(negedge clk);
      set_in(1'b0, 1'b1, 6'h00, 6'h00);
      cnt = 0;
      for (int k = 1; k <= 30 && cnt == 0; k++) begin
         @(negedge clk);
         if (b1.done) cnt = k;
      end
      chk("hold_first_latency", cnt, 10);
      chk("hold_first_pass", int'(b1.pass), 1);
      @(negedge clk);
      chk("hold_pass_cleared", int'(b1.pass), 0);
      chk("hold_busy_again", int'(b1.busy), 1);
      chk("hold_sel_restart", int'(b1.sel), 0);
      cnt = 0;
      for (int k = 2; k <= 30 && cnt == 0; k++) begin
         @(negedge clk);
         if (b1.done) cnt = k;
      end
      chk("hold_second_latency", cnt, 10);
      chk("hold_second_pass", int'(b1.pass), 1);
      set_in(1'b0, 1'b0, 6'h00, 6'h00);
      repeat (12) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
